// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor-count defaults, motion states and the
// step-direction encoding used on mux_sig.
package elevator_pkg;

    localparam int FLOORS_DEF  = 8;
    localparam int FLOOR_W_DEF = $clog2(FLOORS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } motion_state_t;

    localparam logic STEP_UP = 1'b1;
    localparam logic STEP_DN = 1'b0;

endpackage

// File: rtl/car_motion_unit_if.sv
// Controller <-> car motion unit handshake: strobes from the controller,
// comparison flags, arrival tick and register status back.
interface car_motion_unit_if
    import elevator_pkg::*;
#(
    parameter int FLOOR_W = FLOOR_W_DEF
);
    logic [FLOOR_W-1:0] dest_req;
    logic               dest_ld;
    logic               dest_clr;
    logic               floor_ld;
    logic               floor_clr;
    logic               mux_sig;
    logic               run;
    logic               dir;
    logic               hold2;
    logic               timer_reset;
    logic               dest_less;
    logic               dest_more;
    logic               arrive;
    logic [FLOOR_W-1:0] cur_floor;
    logic [FLOOR_W-1:0] dest_floor;
    logic               moving;

    modport master (
        output dest_req, dest_ld, dest_clr, floor_ld, floor_clr, mux_sig,
               run, dir, hold2, timer_reset,
        input  dest_less, dest_more, arrive, cur_floor, dest_floor, moving
    );

    modport slave (
        input  dest_req, dest_ld, dest_clr, floor_ld, floor_clr, mux_sig,
               run, dir, hold2, timer_reset,
        output dest_less, dest_more, arrive, cur_floor, dest_floor, moving
    );
endinterface

// File: rtl/travel_timer.sv
// Inter-floor travel timer: counts TRAVEL_TICKS cycles of run per floor and
// emits a registered one-cycle arrive tick at terminal count.
//
//   state | meaning
//   IDLE  | not travelling, cnt held at 0
//   RUN   | travelling, cnt advancing while run is high
//   HOLD  | travel paused, cnt frozen
module travel_timer
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 100_000_000,
    parameter int CNT_W        = $clog2(TRAVEL_TICKS)
) (
    input  logic CLK,
    input  logic reset,
    input  logic run,
    input  logic hold2,
    input  logic timer_reset,
    output logic arrive,
    output logic moving
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_TICKS - 1);

    motion_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             arrive_nxt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            arrive <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            arrive <= arrive_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        arrive_nxt = 1'b0;
        if (timer_reset) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (run) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt    = '0;
                            arrive_nxt = 1'b1;
                            state_nxt  = IDLE;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else if (hold2) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HOLD: begin
                    // Resume counts on the same edge so each paused cycle costs exactly one.
                    if (run) begin
                        state_nxt = RUN;
                        if (cnt != CNT_LAST) cnt_nxt = cnt + 1'b1;
                    end else if (!hold2) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign moving = (state == RUN) || (state == HOLD);

endmodule

// File: rtl/car_motion_unit.sv
// Car motion datapath: destination and current-floor registers, their
// comparison flags, and the travel timer that times each one-floor move.
module car_motion_unit
    import elevator_pkg::*;
#(
    parameter int FLOORS       = FLOORS_DEF,
    parameter int FLOOR_W      = $clog2(FLOORS),
    parameter int TRAVEL_TICKS = 100_000_000
) (
    input  logic              CLK,
    input  logic              reset,
    car_motion_unit_if.slave  bus
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

    logic [FLOOR_W-1:0] dest_q;
    logic [FLOOR_W-1:0] cur_q;
    logic               req_valid;

    // Widen before comparing so out-of-range requests are caught at any FLOOR_W.
    assign req_valid = (32'(bus.dest_req) < 32'(FLOORS));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            dest_q <= '0;
        end else if (bus.dest_clr) begin
            dest_q <= '0;
        end else if (bus.dest_ld && req_valid) begin
            dest_q <= bus.dest_req;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cur_q <= '0;
        end else if (bus.floor_clr) begin
            cur_q <= '0;
        end else if (bus.floor_ld) begin
            if (bus.mux_sig == STEP_UP) begin
                if (cur_q != TOP_FLOOR) cur_q <= cur_q + 1'b1;
            end else begin
                if (cur_q != '0) cur_q <= cur_q - 1'b1;
            end
        end
    end

    assign bus.dest_less  = (dest_q < cur_q);
    assign bus.dest_more  = (dest_q > cur_q);
    assign bus.cur_floor  = cur_q;
    assign bus.dest_floor = dest_q;

    travel_timer #(
        .TRAVEL_TICKS (TRAVEL_TICKS)
    ) u_travel_timer (
        .CLK         (CLK),
        .reset       (reset),
        .run         (bus.run),
        .hold2       (bus.hold2),
        .timer_reset (bus.timer_reset),
        .arrive      (bus.arrive),
        .moving      (bus.moving)
    );

endmodule

// File: tb/tb_car_motion_unit.sv
// Directed bench for car_motion_unit with FLOORS=8, TRAVEL_TICKS=4; a 4-bit
// floor field lets out-of-range requests such as 9 reach the destination logic.
module tb_car_motion_unit;

    logic CLK;
    logic reset;
    int   n_tests;
    int   n_fail;

    car_motion_unit_if #(.FLOOR_W(4)) bus ();

    car_motion_unit #(
        .FLOORS       (8),
        .FLOOR_W      (4),
        .TRAVEL_TICKS (4)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cur"},    32'(bus.cur_floor),  0);
        chk({tag, "_dest"},   32'(bus.dest_floor), 0);
        chk({tag, "_less"},   32'(bus.dest_less),  0);
        chk({tag, "_more"},   32'(bus.dest_more),  0);
        chk({tag, "_arrive"}, 32'(bus.arrive),     0);
        chk({tag, "_moving"}, 32'(bus.moving),     0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset           = 1'b0;
        bus.dest_req    = '0;
        bus.dest_ld     = 1'b0;
        bus.dest_clr    = 1'b0;
        bus.floor_ld    = 1'b0;
        bus.floor_clr   = 1'b0;
        bus.mux_sig     = 1'b0;
        bus.run         = 1'b0;
        bus.dir         = 1'b0;
        bus.hold2       = 1'b0;
        bus.timer_reset = 1'b0;

        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b1;
        tick();

        // destination load and out-of-range request
        bus.dest_req = 4'd5; bus.dest_ld = 1'b1;
        tick();
        bus.dest_ld = 1'b0;
        chk("dest_ld5",   32'(bus.dest_floor), 5);
        chk("dest_more5", 32'(bus.dest_more),  1);
        chk("dest_less5", 32'(bus.dest_less),  0);
        bus.dest_req = 4'd9; bus.dest_ld = 1'b1;
        tick();
        bus.dest_ld = 1'b0;
        chk("dest_ign9",  32'(bus.dest_floor), 5);

        // one-floor step: arrive exactly 4 cycles after timer_reset edge
        bus.dir = 1'b1;
        bus.timer_reset = 1'b1;
        tick();
        bus.timer_reset = 1'b0;
        bus.run = 1'b1;
        chk("step_moving0", 32'(bus.moving), 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("step_arr%0d", i), 32'(bus.arrive), (i == 4) ? 1 : 0);
        end
        chk("step_idle", 32'(bus.moving), 0);
        bus.run = 1'b0;
        bus.floor_ld = 1'b1; bus.mux_sig = 1'b1;
        tick();
        bus.floor_ld = 1'b0;
        chk("step_cur1", 32'(bus.cur_floor), 1);

        // hold for 3 cycles after 2 counts: arrive 7 cycles after timer_reset
        bus.timer_reset = 1'b1;
        tick();
        bus.timer_reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i >= 3 && i <= 5) begin
                bus.run = 1'b0; bus.hold2 = 1'b1;
            end else begin
                bus.run = 1'b1; bus.hold2 = 1'b0;
            end
            tick();
            chk($sformatf("hold_arr%0d", i), 32'(bus.arrive), (i == 7) ? 1 : 0);
            chk($sformatf("hold_mov%0d", i), 32'(bus.moving), (i < 7) ? 1 : 0);
        end
        bus.run = 1'b0;

        // saturation at both ends, clear beats step
        bus.floor_clr = 1'b1;
        tick();
        bus.floor_clr = 1'b0;
        chk("sat_clr", 32'(bus.cur_floor), 0);
        bus.floor_ld = 1'b1; bus.mux_sig = 1'b0;
        tick();
        chk("sat_lo", 32'(bus.cur_floor), 0);
        bus.mux_sig = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        bus.floor_ld = 1'b0;
        chk("sat_hi",   32'(bus.cur_floor), 7);
        chk("sat_less", 32'(bus.dest_less), 1);
        chk("sat_more", 32'(bus.dest_more), 0);
        bus.mux_sig = 1'b0; bus.floor_ld = 1'b1;
        tick();
        bus.floor_ld = 1'b0;
        chk("sat_dn6", 32'(bus.cur_floor), 6);
        bus.floor_clr = 1'b1; bus.floor_ld = 1'b1; bus.mux_sig = 1'b1;
        tick();
        bus.floor_clr = 1'b0; bus.floor_ld = 1'b0;
        chk("clr_wins", 32'(bus.cur_floor), 0);

        // simultaneous floor and destination updates, clear priority, equal flags
        bus.floor_ld = 1'b1; bus.mux_sig = 1'b1;
        bus.dest_ld = 1'b1; bus.dest_req = 4'd2;
        tick();
        bus.floor_ld = 1'b0; bus.dest_ld = 1'b0;
        chk("both_cur",  32'(bus.cur_floor),  1);
        chk("both_dest", 32'(bus.dest_floor), 2);
        bus.dest_clr = 1'b1; bus.dest_ld = 1'b1; bus.dest_req = 4'd6;
        tick();
        bus.dest_clr = 1'b0; bus.dest_ld = 1'b0;
        chk("dclr_wins", 32'(bus.dest_floor), 0);
        chk("dclr_less", 32'(bus.dest_less),  1);
        bus.floor_clr = 1'b1;
        tick();
        bus.floor_clr = 1'b0;
        chk("eq_less", 32'(bus.dest_less), 0);
        chk("eq_more", 32'(bus.dest_more), 0);

        // restart on the terminal-count edge suppresses arrive
        bus.timer_reset = 1'b1;
        tick();
        bus.timer_reset = 1'b0;
        bus.run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            bus.timer_reset = (i == 4);
            tick();
            chk($sformatf("rst_arr%0d", i), 32'(bus.arrive), (i == 8) ? 1 : 0);
        end
        bus.timer_reset = 1'b0;
        bus.run = 1'b0;

        // asynchronous reset mid-travel
        bus.dest_req = 4'd3; bus.dest_ld = 1'b1;
        bus.floor_ld = 1'b1; bus.mux_sig = 1'b1;
        bus.timer_reset = 1'b1;
        tick();
        bus.dest_ld = 1'b0; bus.floor_ld = 1'b0; bus.timer_reset = 1'b0;
        bus.run = 1'b1;
        tick();
        chk("pre_rst_dest", 32'(bus.dest_floor), 3);
        chk("pre_rst_mov",  32'(bus.moving),     1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("post_rst_arr%0d", i), 32'(bus.arrive), 0);
        end
        chk("post_rst_mov", 32'(bus.moving), 0);
        bus.run = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
